// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Groups the fetch-side and decode-side signals of the fetch queue.
//   Fetch side : IF_valid_1/2, IF_instruction_1/2, IF_pc in; fq_ready, pc_stall out
//   Decode side: ID_valid_1/2, ID_instruction_1/2, ID_pc_1/2 out; ID_take in
// The slave modport is the queue itself; the master modport is the
// surrounding fetch/decode logic that drives it.
interface fetch_queue_if #(
  parameter int IW = 32,
  parameter int AW = 8
);
  logic          IF_valid_1;
  logic          IF_valid_2;
  logic [IW-1:0] IF_instruction_1;
  logic [IW-1:0] IF_instruction_2;
  logic [AW-1:0] IF_pc;
  logic          fq_ready;
  logic          pc_stall;
  logic          ID_valid_1;
  logic          ID_valid_2;
  logic [IW-1:0] ID_instruction_1;
  logic [IW-1:0] ID_instruction_2;
  logic [AW-1:0] ID_pc_1;
  logic [AW-1:0] ID_pc_2;
  logic [1:0]    ID_take;

  modport master (
    output IF_valid_1, IF_valid_2, IF_instruction_1, IF_instruction_2, IF_pc,
    output ID_take,
    input  fq_ready, pc_stall,
    input  ID_valid_1, ID_valid_2, ID_instruction_1, ID_instruction_2,
    input  ID_pc_1, ID_pc_2
  );

  modport slave (
    input  IF_valid_1, IF_valid_2, IF_instruction_1, IF_instruction_2, IF_pc,
    input  ID_take,
    output fq_ready, pc_stall,
    output ID_valid_1, ID_valid_2, ID_instruction_1, ID_instruction_2,
    output ID_pc_1, ID_pc_2
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Dual-slot circular instruction queue between fetch and dual-issue decode.
// Accepts 0-2 instructions per cycle, presents the two oldest entries, and
// lets decode pop 0-2 per cycle. Flush (branch redirect) empties the queue.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-high reset, clears pointers, count and storage
//   flush - discard all entries; wins over push and pop in the same cycle
//   bus   - fetch_queue_if.slave (fetch pair in, decode pair out, backpressure)
//   count - current occupancy (0..DEPTH)
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  fetch_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic          ready;
  logic [1:0]    push_n;
  logic [1:0]    take_n;
  logic [1:0]    pop_n;

  // Pointers wrap naturally because they are exactly log2(DEPTH) bits wide.
  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Room for a full pair is judged from the registered count only, so a pop
  // in the same cycle never opens space for a push.
  assign ready        = (count <= CW'(DEPTH - 2));
  assign bus.fq_ready = ready;
  assign bus.pc_stall = ~ready;

  assign bus.ID_valid_1       = (count != CW'(0));
  assign bus.ID_valid_2       = (count >= CW'(2));
  assign bus.ID_instruction_1 = instr_mem[head];
  assign bus.ID_instruction_2 = instr_mem[head_p1];
  assign bus.ID_pc_1          = pc_mem[head];
  assign bus.ID_pc_2          = pc_mem[head_p1];

  // Push/pop amounts for this cycle. Slot 2 only counts behind slot 1, and
  // the pop is clamped to what is actually valid so count cannot underflow.
  always_comb begin
    push_n = 2'd0;
    if (ready && bus.IF_valid_1)
      push_n = bus.IF_valid_2 ? 2'd2 : 2'd1;
    take_n = (bus.ID_take == 2'd3) ? 2'd2 : bus.ID_take;
    pop_n  = take_n;
    if (count == CW'(0))
      pop_n = 2'd0;
    else if (count == CW'(1) && take_n == 2'd2)
      pop_n = 2'd1;
  end

  // Queue state. Flush only rewinds the pointers; stale storage is harmless
  // because the valids are derived from count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) begin
        instr_mem[tail] <= bus.IF_instruction_1;
        pc_mem[tail]    <= bus.IF_pc;
      end
      if (push_n == 2'd2) begin
        instr_mem[tail_p1] <= bus.IF_instruction_2;
        pc_mem[tail_p1]    <= bus.IF_pc + AW'(1);
      end
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the entries.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int AW    = 8;
  localparam int CW    = 4;

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] pc;
  } entry_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;

  int checks;
  int errors;
  entry_t mq[$];

  fetch_queue_if #(.IW(IW), .AW(AW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: applies one clock edge worth of queue behaviour
  task automatic model_step();
    int p, t, q;
    logic [AW-1:0] pc2;
    if (flush) begin
      mq.delete();
    end else begin
      p = 0;
      if (mq.size() <= DEPTH - 2 && bus.IF_valid_1)
        p = bus.IF_valid_2 ? 2 : 1;
      t = (bus.ID_take == 2'd3) ? 2 : int'(bus.ID_take);
      q = (t < mq.size()) ? t : mq.size();
      repeat (q) void'(mq.pop_front());
      pc2 = bus.IF_pc + 8'd1;
      if (p >= 1) mq.push_back('{ins: bus.IF_instruction_1, pc: bus.IF_pc});
      if (p == 2) mq.push_back('{ins: bus.IF_instruction_2, pc: pc2});
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, idle the inputs
  task automatic cycle(input bit v1, input bit v2, input logic [IW-1:0] i1,
                       input logic [IW-1:0] i2, input logic [AW-1:0] pc,
                       input logic [1:0] take, input bit fl);
    bus.IF_valid_1       = v1;
    bus.IF_valid_2       = v2;
    bus.IF_instruction_1 = i1;
    bus.IF_instruction_2 = i2;
    bus.IF_pc            = pc;
    bus.ID_take          = take;
    flush                = fl;
    @(posedge clk);
    model_step();
    #1;
    bus.IF_valid_1 = 1'b0;
    bus.IF_valid_2 = 1'b0;
    bus.ID_take    = 2'd0;
    flush          = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.IF_valid_1 = 1'b0; bus.IF_valid_2 = 1'b0;
    bus.IF_instruction_1 = '0; bus.IF_instruction_2 = '0;
    bus.IF_pc = '0; bus.ID_take = 2'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== 4'd0 || bus.fq_ready !== 1'b1 || bus.pc_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: count=%0d ready=%b stall=%b expected 0/1/0", count, bus.fq_ready, bus.pc_stall);
    end
    checks++;
    if (bus.ID_valid_1 !== 1'b0 || bus.ID_valid_2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b%b expected 00", bus.ID_valid_1, bus.ID_valid_2);
    end
    checks++;
    if (bus.ID_instruction_1 !== '0 || bus.ID_instruction_2 !== '0 ||
        bus.ID_pc_1 !== '0 || bus.ID_pc_2 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h %h expected zeros", bus.ID_instruction_1,
               bus.ID_instruction_2, bus.ID_pc_1, bus.ID_pc_2);
    end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    cycle(1, 1, 32'h1, 32'h2, 8'h40, 2'd0, 0);
    cycle(1, 1, 32'h3, 32'h4, 8'h42, 2'd0, 0);
    cycle(1, 0, 32'h5, 32'h0, 8'h44, 2'd0, 0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL midfill_count: got %0d expected 5", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || bus.ID_valid_1 !== 1'b0 || bus.fq_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: count=%0d valid1=%b ready=%b expected 0/0/1", count, bus.ID_valid_1, bus.fq_ready);
    end
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_push_pairs();
    do_reset();
    bus.IF_valid_1 = 1'b1; bus.IF_valid_2 = 1'b1;
    bus.IF_instruction_1 = 32'h11; bus.IF_instruction_2 = 32'h22; bus.IF_pc = 8'h10;
    #1;
    checks++;
    if (bus.ID_valid_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_bypass: valid1 got %b expected 0", bus.ID_valid_1);
    end
    cycle(1, 1, 32'h11, 32'h22, 8'h10, 2'd0, 0);
    checks++;
    if (bus.ID_valid_1 !== 1'b1 || bus.ID_instruction_1 !== 32'h11) begin
      errors++;
      $display("[TB] FAIL push_latency: valid1=%b ins1=%h expected 1/11", bus.ID_valid_1, bus.ID_instruction_1);
    end
    cycle(1, 1, 32'h33, 32'h44, 8'h12, 2'd0, 0);
    checks++;
    if (count !== 4'd4) begin
      errors++;
      $display("[TB] FAIL pairs_count: got %0d expected 4", count);
    end
    checks++;
    if (bus.ID_instruction_1 !== 32'h11 || bus.ID_instruction_2 !== 32'h22 ||
        bus.ID_pc_1 !== 8'h10 || bus.ID_pc_2 !== 8'h11) begin
      errors++;
      $display("[TB] FAIL pairs_head: got %h@%h %h@%h expected 11@10 22@11", bus.ID_instruction_1,
               bus.ID_pc_1, bus.ID_instruction_2, bus.ID_pc_2);
    end
    cycle(0, 0, '0, '0, '0, 2'd1, 0);
    checks++;
    if (count !== 4'd3 || bus.ID_instruction_1 !== 32'h22 || bus.ID_pc_1 !== 8'h11 ||
        bus.ID_instruction_2 !== 32'h33 || bus.ID_pc_2 !== 8'h12) begin
      errors++;
      $display("[TB] FAIL take_one: count=%0d %h@%h %h@%h expected 3 22@11 33@12", count,
               bus.ID_instruction_1, bus.ID_pc_1, bus.ID_instruction_2, bus.ID_pc_2);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 32'h100 + 2 * i, 32'h101 + 2 * i, 8'(8'h20 + 2 * i), 2'd0, 0);
    checks++;
    if (count !== 4'd6 || bus.fq_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_six: count=%0d ready=%b expected 6/1", count, bus.fq_ready);
    end
    cycle(1, 0, 32'h106, 32'h0, 8'h26, 2'd0, 0);
    checks++;
    if (count !== 4'd7 || bus.fq_ready !== 1'b0 || bus.pc_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_seven: count=%0d ready=%b stall=%b expected 7/0/1", count, bus.fq_ready, bus.pc_stall);
    end
    cycle(1, 1, 32'hDEAD, 32'hBEEF, 8'h80, 2'd0, 0);
    checks++;
    if (count !== 4'd7 || bus.ID_instruction_1 !== 32'h100) begin
      errors++;
      $display("[TB] FAIL full_drop: count=%0d ins1=%h expected 7/100", count, bus.ID_instruction_1);
    end
    cycle(0, 0, '0, '0, '0, 2'd2, 0);
    checks++;
    if (count !== 4'd5 || bus.fq_ready !== 1'b1 || bus.ID_instruction_1 !== 32'h102) begin
      errors++;
      $display("[TB] FAIL fill_pop: count=%0d ready=%b ins1=%h expected 5/1/102", count, bus.fq_ready, bus.ID_instruction_1);
    end
  endtask

  task automatic test_steady();
    logic [IW-1:0] seq;
    logic [AW-1:0] pc;
    do_reset();
    seq = 32'hA000;
    pc  = 8'hF0;
    cycle(1, 0, seq, '0, pc, 2'd0, 0);
    seq += 1; pc += 1;
    cycle(1, 1, seq, seq + 1, pc, 2'd0, 0);
    seq += 2; pc += 2;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, seq, seq + 1, pc, 2'd2, 0);
      seq += 2; pc += 2;
      checks++;
      if (count !== 4'd3 || mq.size() != 3) begin
        errors++;
        $display("[TB] FAIL steady_count: got %0d expected 3", count);
      end
      checks++;
      if (bus.ID_instruction_1 !== mq[0].ins || bus.ID_pc_1 !== mq[0].pc ||
          bus.ID_instruction_2 !== mq[1].ins || bus.ID_pc_2 !== mq[1].pc) begin
        errors++;
        $display("[TB] FAIL steady_head: got %h@%h %h@%h expected %h@%h %h@%h", bus.ID_instruction_1,
                 bus.ID_pc_1, bus.ID_instruction_2, bus.ID_pc_2, mq[0].ins, mq[0].pc, mq[1].ins, mq[1].pc);
      end
    end
    while (mq.size() > 0) begin
      checks++;
      if (bus.ID_instruction_1 !== mq[0].ins || bus.ID_pc_1 !== mq[0].pc) begin
        errors++;
        $display("[TB] FAIL drain_head: got %h@%h expected %h@%h", bus.ID_instruction_1, bus.ID_pc_1,
                 mq[0].ins, mq[0].pc);
      end
      cycle(0, 0, '0, '0, '0, 2'd1, 0);
    end
    checks++;
    if (count !== 4'd0 || bus.ID_valid_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty: count=%0d valid1=%b expected 0/0", count, bus.ID_valid_1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 1, 32'h51, 32'h52, 8'h30, 2'd0, 0);
    cycle(1, 1, 32'h53, 32'h54, 8'h32, 2'd0, 0);
    cycle(1, 1, 32'h55, 32'h56, 8'h34, 2'd2, 1);
    checks++;
    if (count !== 4'd0 || bus.ID_valid_1 !== 1'b0 || bus.ID_valid_2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush: count=%0d valid=%b%b expected 0 00", count, bus.ID_valid_1, bus.ID_valid_2);
    end
    cycle(1, 1, 32'h61, 32'h62, 8'h50, 2'd0, 0);
    checks++;
    if (count !== 4'd2 || bus.ID_instruction_1 !== 32'h61 || bus.ID_pc_2 !== 8'h51) begin
      errors++;
      $display("[TB] FAIL after_flush: count=%0d ins1=%h pc2=%h expected 2/61/51", count, bus.ID_instruction_1, bus.ID_pc_2);
    end
  endtask

  task automatic test_overtake();
    do_reset();
    cycle(1, 0, 32'h77, 32'h0, 8'h05, 2'd0, 0);
    cycle(0, 0, '0, '0, '0, 2'd2, 0);
    checks++;
    if (count !== 4'd0 || bus.fq_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overtake: count=%0d ready=%b expected 0/1", count, bus.fq_ready);
    end
    cycle(0, 0, '0, '0, '0, 2'd3, 0);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL empty_take: count=%0d expected 0", count);
    end
    cycle(0, 1, 32'h88, 32'h99, 8'h07, 2'd0, 0);
    checks++;
    if (count !== 4'd0 || bus.ID_valid_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL slot2_only: count=%0d valid1=%b expected 0/0", count, bus.ID_valid_1);
    end
    cycle(1, 1, 32'hAA, 32'hBB, 8'hFF, 2'd0, 0);
    checks++;
    if (bus.ID_pc_1 !== 8'hFF || bus.ID_pc_2 !== 8'h00 || bus.ID_instruction_2 !== 32'hBB) begin
      errors++;
      $display("[TB] FAIL pc_wrap: pc1=%h pc2=%h ins2=%h expected ff/00/bb", bus.ID_pc_1, bus.ID_pc_2, bus.ID_instruction_2);
    end
  endtask

  task automatic test_random();
    bit v1, v2, fl;
    logic [1:0] take;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v1   = ($urandom_range(0, 3) != 0);
      v2   = 1'($urandom_range(0, 1));
      take = (i < 150) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 39) == 0);
      cycle(v1, v2, $urandom, $urandom, 8'($urandom_range(0, 255)), take, fl);
      checks++;
      if (count !== CW'(mq.size()) || bus.fq_ready !== (mq.size() <= DEPTH - 2) ||
          bus.pc_stall !== (mq.size() > DEPTH - 2)) begin
        errors++;
        $display("[TB] FAIL rand_status %0d: count=%0d ready=%b stall=%b expected count %0d", i, count,
                 bus.fq_ready, bus.pc_stall, mq.size());
      end
      checks++;
      if (bus.ID_valid_1 !== (mq.size() >= 1) || bus.ID_valid_2 !== (mq.size() >= 2)) begin
        errors++;
        $display("[TB] FAIL rand_valid %0d: got %b%b for %0d entries", i, bus.ID_valid_1, bus.ID_valid_2, mq.size());
      end
      if (mq.size() >= 1) begin
        checks++;
        if (bus.ID_instruction_1 !== mq[0].ins || bus.ID_pc_1 !== mq[0].pc) begin
          errors++;
          $display("[TB] FAIL rand_slot1 %0d: got %h@%h expected %h@%h", i, bus.ID_instruction_1,
                   bus.ID_pc_1, mq[0].ins, mq[0].pc);
        end
      end
      if (mq.size() >= 2) begin
        checks++;
        if (bus.ID_instruction_2 !== mq[1].ins || bus.ID_pc_2 !== mq[1].pc) begin
          errors++;
          $display("[TB] FAIL rand_slot2 %0d: got %h@%h expected %h@%h", i, bus.ID_instruction_2,
                   bus.ID_pc_2, mq[1].ins, mq[1].pc);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_midfill();
    test_push_pairs();
    test_fill();
    test_steady();
    test_flush();
    test_overtake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-slot instruction queue between the fetch stage and the dual-issue decode stage of the in-order superscalar core. Each cycle it accepts 0–2 instructions from fetch (the instruction-memory pair plus the fetch PC) and presents the two oldest entries to decode. Decode pops 0–2 entries per cycle. The block provides the PC-stall backpressure and a branch-redirect flush.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 4
- IW, 32, instruction width
- AW, 8, PC / instruction-address width (word index)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  discard all entries (branch redirect)
- IF_valid_1  in  1  fetch slot 1 holds an instruction
- IF_valid_2  in  1  fetch slot 2 holds an instruction; ignored unless IF_valid_1
- IF_instruction_1  in  IW  fetch slot 1 instruction
- IF_instruction_2  in  IW  fetch slot 2 instruction
- IF_pc  in  AW  address of slot 1; slot 2 address is IF_pc+1 mod 2^AW
- fq_ready  out  1  at least 2 free entries
- pc_stall  out  1  equals ~fq_ready; the PC holds while high
- ID_valid_1  out  1  head entry valid
- ID_valid_2  out  1  head+1 entry valid
- ID_instruction_1  out  IW  head instruction
- ID_instruction_2  out  IW  head+1 instruction
- ID_pc_1  out  AW  head PC
- ID_pc_2  out  AW  head+1 PC
- ID_take  in  2  entries consumed by decode this cycle (0, 1, 2; 3 treated as 2)
- count  out  clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: entries of {instruction, pc}. Pointers are head (rd) and tail (wr), each clog2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in a count register.
- Push count per cycle:
  - p = 0 if ~fq_ready or ~IF_valid_1
  - p = 1 if IF_valid_1 & ~IF_valid_2
  - p = 2 if IF_valid_1 & IF_valid_2
- When p ≥ 1, slot 1 is written at tail with IF_pc. When p = 2, slot 2 is written at tail+1 with IF_pc+1.
- Pop count: q = min(ID_take clamped to 2, ID_valid_1 + ID_valid_2). Over-take is silently clamped; count never underflows.
- Next state: head += q; tail += p; count += p − q.
- Simultaneous push and pop are both applied in the same edge.
- Flush has priority over push and pop in the same cycle: head, tail and count go to 0, and entry contents are left as is.
- Outputs are combinational reads of the registered state:
  - ID_valid_1 = (count ≥ 1)
  - ID_valid_2 = (count ≥ 2)
  - ID_instruction_n / ID_pc_n read entries head and head+1 (wrapping)
- fq_ready = (DEPTH − count ≥ 2), computed from registered count only; same-cycle pops do not add space.
- No bypass: a pushed instruction is visible on the ID outputs no earlier than the next cycle.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - head = tail = count = 0 and all storage cleared to 0
  - outputs: ID_valid_1/2 = 0, ID_instruction_1/2 = 0, ID_pc_1/2 = 0, fq_ready = 1, pc_stall = 0, count = 0
- Reset asserted mid-operation clears the queue immediately without waiting for clk; pending push/pop in that cycle are lost.
- Push-to-output latency is 1 cycle. The pop takes effect at the edge, and the next head appears the following cycle.
- Full boundary: at count = DEPTH−1 or DEPTH, fq_ready = 0 and fetch data is ignored even if valid. fq_ready returns the cycle after count drops to ≤ DEPTH−2.
- Empty boundary: count = 0 → both ID_valid low, and ID_take is ignored.
- Wrap-around: a two-instruction push at tail = DEPTH−1 writes entries DEPTH−1 and 0. A head read at DEPTH−1 presents entry 0 as slot 2.
- PC wrap: IF_pc = 2^AW−1 gives slot-2 PC 0.

## Test plan
- Reset then idle → count 0, fq_ready 1, ID_valid_1/2 0, ID outputs 0; assert reset mid-fill with count 5 → count 0 within the same cycle, before the next clk.
- Push pairs (0x11,0x22 @pc 0x10), (0x33,0x44 @pc 0x12) with ID_take 0 → count 4; ID_instruction_1/2 = 0x11/0x22, ID_pc_1/2 = 0x10/0x11. Then ID_take 1 → next cycle head 0x22 @0x11, slot 2 0x33 @0x12.
- Fill with no pops: 3 pairs plus a single → count 7 and fq_ready 0; a further valid pair is dropped and count stays 7. Pop 2 → count 5, fq_ready 1 next cycle.
- Steady state: push 2 and take 2 each cycle for 12 cycles (pointers wrap) → count constant, in-order instruction/PC stream with no loss or duplication; a pair pushed at tail 7 lands in entries 7 and 0.
- Flush with a simultaneous push of a pair and ID_take 2 at count 4 → count 0 next cycle, ID_valid low, pushed pair discarded.
- Over-take: count 1 with ID_take 2 → count 0 with no underflow. IF_valid_2 = 1 with IF_valid_1 = 0 → no push. IF_pc = 0xFF pair → ID_pc_2 = 0x00.
